serial_add_ctrl: RTL and testbench

Multi-cycle digit-serial adder/subtractor controller. Time-shares one 2-bit ripple adder slice across a WIDTH-bit operation, two bits per cycle, LSB digit first. Uses a start/busy/done handshake and serves as a low-area alternative add path for the ALU.

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/serial_add_ctrl_fa2.sv | 23 ++
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial add/subtract controller.
//   state_e : controller FSM encoding (idle / run / done)
//   DIGIT   : bits consumed per cycle by the adder slice
package serial_add_ctrl_pkg;

    localparam int unsigned DIGIT = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl.
//   start, sub, a, b : request side, sampled by the controller when not busy
//   busy, done       : handshake status
//   sum, c_out, ovf  : registered result, held until the next completion
// Modports: master = requester, slave = controller.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 32
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_fa2.sv
// FA2: 2-bit ripple full-adder slice, purely combinational.
//   a, b  : digit operands
//   c_in  : carry into bit 0
//   s     : digit sum
//   c_out : carry out of bit 1
module serial_add_ctrl_fa2
    import serial_add_ctrl_pkg::*;
(
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out
);

    logic c_mid;

    always_comb begin
        {c_mid, s[0]} = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, c_in};
        {c_out, s[1]} = {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, c_mid};
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial adder/subtractor controller. One FA2 slice is reused for
// WIDTH/2 cycles, LSB digit first; subtraction is a + ~b + 1.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_add_ctrl_if slave (start/sub/a/b in, busy/done/sum/c_out/ovf out)
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sha_q, sha_d;
    logic [WIDTH-1:0]  shb_q, shb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  slice_s;
    logic              slice_c;
    logic [WIDTH-1:0]  res_next;

    serial_add_ctrl_fa2 u_fa2 (
        .a     (sha_q[DIGIT-1:0]),
        .b     (shb_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // New digit enters at the top so the last digit lands in the MSBs.
    assign res_next = {slice_s, res_q[WIDTH-1:DIGIT]};

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    sha_d   = bus.a;
                    shb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1] ^ bus.sub;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sha_d   = sha_q >> DIGIT;
                shb_d   = shb_q >> DIGIT;
                res_d   = res_next;
                carry_d = slice_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                    sum_d   = res_next;
                    c_out_d = slice_c;
                    ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy  = (state_q == StRun);
    assign bus.done  = (state_q == StDone);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=32).
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 16;
    localparam int          LIMIT = 40;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request so it is sampled by the next rising edge; return 1 time unit after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Advance at least one edge, until done is seen or the bound expires.
    task automatic wait_done(input string tag, output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) busy_cycles++;
            if (bus.busy && bus.done) check({tag, "_busy_and_done"}, 64'd1, 64'd0);
        end while (!bus.done && edges < LIMIT);
        check({tag, "_done_seen"}, {63'd0, bus.done}, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] es, input logic ec,
                                input logic eo);
        check({tag, "_sum"}, {32'd0, bus.sum}, {32'd0, es});
        check({tag, "_c_out"}, {63'd0, bus.c_out}, {63'd0, ec});
        check({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, eo});
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] es, input logic ec,
                          input logic eo);
        int edges;
        int bc;
        int b0;
        start_op(a, b, sub);
        b0 = bus.busy ? 1 : 0;
        wait_done(tag, edges, bc);
        check({tag, "_latency"}, 64'(edges), 64'(LAT));
        check({tag, "_busy_cycles"}, 64'(b0 + bc), 64'(LAT));
        check_result(tag, es, ec, eo);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_sum_held"}, {32'd0, bus.sum}, {32'd0, es});
    endtask

    initial begin
        int edges;
        int bc;
        int dones;
        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset with start held and random operands.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sub   = 1'($urandom_range(1));
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check_result("rst", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        dones     = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("idle_no_done", 64'(dones), 64'd0);

        // Basic add, carry-out, overflow and subtract vectors.
        run_op("add_5_3", 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_5_7", 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Start pulse mid-run is ignored.
        start_op(32'h5, 32'h3, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd200;
        bus.sub   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ign", edges, bc);
        check("ign_latency", 64'(edges), 64'(LAT - 5));
        check_result("ign", 32'h8, 1'b0, 1'b0);

        // Start during the DONE cycle is accepted back-to-back.
        bus.start = 1'b1;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h1111_1111;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", {63'd0, bus.busy}, 64'd1);
        wait_done("b2b", edges, bc);
        check("b2b_spacing", 64'(edges + 1), 64'd17);
        check_result("b2b", 32'h2345_6789, 1'b0, 1'b0);

        // Reset mid-operation aborts without a done pulse.
        start_op(32'hDEAD_BEEF, 32'h1, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_sum", {32'd0, bus.sum}, 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op("after_abort", 32'hA, 32'h3, 1'b1, 32'h7, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
